// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stimulus vector sequencer.
// Holds the FSM state enum, default widths and the MISR step.
package stim_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  localparam int VEC_W  = 3;
  localparam int ADDR_W = 10;
  localparam int RSP_W  = 6;

  localparam logic [15:0] MISR_POLY = 16'h1021;

  localparam int OBS_BIT      = 2;
  localparam int CONT_EQL_BIT = 1;
  localparam int EQL_BIT      = 0;

  function automatic logic [15:0] misr_next(
    input logic [15:0] s,
    input logic [15:0] d
  );
    logic [15:0] fb;
    fb = s[15] ? MISR_POLY : 16'h0000;
    return {s[14:0], 1'b0} ^ fb ^ d;
  endfunction

endpackage

// File: rtl/stim_vec_sequencer_if.sv
// Vector-memory load bus between the harness loader and the sequencer.
// master drives the write, slave (sequencer) consumes it.
interface stim_vec_sequencer_if #(
  parameter int ADDR_W = stim_seq_pkg::ADDR_W,
  parameter int VEC_W  = stim_seq_pkg::VEC_W
);

  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [VEC_W-1:0]  load_data;

  modport master (
    output load_we,
    output load_addr,
    output load_data
  );

  modport slave (
    input load_we,
    input load_addr,
    input load_data
  );

endinterface

// File: rtl/stim_vec_ram.sv
// Vector memory: one synchronous write port, one registered read port.
// The read register holds when not enabled and clears on reset.
module stim_vec_ram #(
  parameter int DEPTH  = 1011,
  parameter int ADDR_W = stim_seq_pkg::ADDR_W,
  parameter int VEC_W  = stim_seq_pkg::VEC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [VEC_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [VEC_W-1:0]  rdata
);

  logic [VEC_W-1:0] mem [DEPTH];
  logic [VEC_W-1:0] rd_q;
  logic [VEC_W-1:0] rd_d;

  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = mem[raddr];
  end

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign rdata = rd_q;

endmodule

// File: rtl/stim_vec_sequencer.sv
// Replays preloaded vectors onto DUT pins with run/pause/step control.
// Define STIM_SIGNATURE_EN to compact DUT responses into a 16-bit MISR.
module stim_vec_sequencer #(
  parameter int VEC_W  = stim_seq_pkg::VEC_W,
  parameter int DEPTH  = 1011,
  parameter int ADDR_W = stim_seq_pkg::ADDR_W,
  parameter int RSP_W  = stim_seq_pkg::RSP_W
) (
  input  logic                  clock,
  input  logic                  reset,
  stim_vec_sequencer_if.slave   ld,
  input  logic [ADDR_W:0]       length,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic [RSP_W-1:0]      dut_rsp,
  output logic [VEC_W-1:0]      vec_out,
  output logic                  vec_valid,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           signature
);

  import stim_seq_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              vec_valid_q;
  logic              issue;
  logic              last;
  logic              clr_sig;
  logic              idle_like;
  logic              ram_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      vec_valid_q <= issue;
    end
  end

  // stop outranks start, start outranks step.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    issue   = 1'b0;
    clr_sig = 1'b0;
    last    = ({1'b0, pc_q} == len_q - 1'b1);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          len_d   = (length > DEPTH_L) ? DEPTH_L : length;
          pc_d    = '0;
          clr_sig = 1'b1;
          state_d = (len_d == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) state_d = ST_PAUSE;
        else      issue   = 1'b1;
      end
      ST_PAUSE: begin
        if (!stop) begin
          if (start)     state_d = ST_RUN;
          else if (step) issue   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      pc_d = pc_q + 1'b1;
      if (last) state_d = ST_DONE;
    end
  end

  always_comb begin
    idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    done      = (state_q == ST_DONE);
    ram_we    = ld.load_we && idle_like &&
                ({1'b0, ld.load_addr} < DEPTH_L);
  end

  stim_vec_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .VEC_W  (VEC_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we),
    .waddr (ld.load_addr),
    .wdata (ld.load_data),
    .re    (issue),
    .raddr (pc_q),
    .rdata (vec_out)
  );

  assign vec_valid = vec_valid_q;
  assign pc        = pc_q;

`ifdef STIM_SIGNATURE_EN
  logic [15:0] sig_q, sig_d;

  // Fold the response one cycle after each issued vector.
  always_comb begin
    sig_d = sig_q;
    if (clr_sig)          sig_d = '0;
    else if (vec_valid_q) sig_d = misr_next(sig_q, 16'(dut_rsp));
  end

  always_ff @(posedge clock) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  logic sig_unused;
  assign sig_unused = ^{dut_rsp, clr_sig};
  assign signature  = 16'h0000;
`endif

endmodule

// File: tb/tb_stim_vec_sequencer.sv
// Self-checking bench for stim_vec_sequencer against a vector-list model.
// Honours STIM_SIGNATURE_EN when computing the expected signature.
module tb_stim_vec_sequencer;

  localparam int DEPTH = 1011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] length = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic [5:0]  dut_rsp = '0;
  logic [2:0]  vec_out;
  logic        vec_valid;
  logic [9:0]  pc;
  logic        busy;
  logic        done;
  logic [15:0] signature;

  int tests = 0;
  int fails = 0;

  logic [2:0] mdl_mem [DEPTH];
  logic [2:0] got [$];

  stim_vec_sequencer_if ld_if ();

  stim_vec_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .ld        (ld_if),
    .length    (length),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .dut_rsp   (dut_rsp),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .signature (signature)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (vec_valid === 1'b1) got.push_back(vec_out);
  end

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ld_if.load_we   = 1'b1;
      ld_if.load_addr = 10'(i);
      ld_if.load_data = 3'($urandom);
      mdl_mem[i]      = ld_if.load_data;
    end
    @(negedge clock);
    ld_if.load_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [10:0] len);
    @(negedge clock);
    length = len;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done === 1'b1 && vec_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pc(input logic [9:0] tgt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pc === tgt) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (vec_out !== 3'b000) begin
      fails++; $display("FAIL rst_vec got %b exp 000", vec_out);
    end
    tests++;
    if (vec_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_flags got v%b b%b d%b exp 000",
               vec_valid, busy, done);
    end
    tests++;
    if (pc !== 10'd0) begin
      fails++; $display("FAIL rst_pc got %0d exp 0", pc);
    end
    tests++;
    if (signature !== 16'h0000) begin
      fails++; $display("FAIL rst_sig got %h exp 0000", signature);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [2:0] pat [4];
    bit ok;
    int bad;
    pat = '{3'b001, 3'b010, 3'b100, 3'b111};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      ld_if.load_we   = 1'b1;
      ld_if.load_addr = 10'(i);
      ld_if.load_data = pat[i];
      mdl_mem[i]      = pat[i];
    end
    @(negedge clock);
    ld_if.load_we = 1'b0;
    got.delete();
    pulse_start(11'd4);
    tests++;
    if (vec_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_lat1 got v%b b%b exp v0 b1",
               vec_valid, busy);
    end
    @(negedge clock);
    tests++;
    if (vec_valid !== 1'b1 || vec_out !== 3'b001) begin
      fails++;
      $display("FAIL basic_lat2 got v%b %b exp v1 001",
               vec_valid, vec_out);
    end
    wait_idle(20, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL basic_timeout got busy exp done");
    end
    bad = 0;
    for (int i = 0; i < got.size() && i < 4; i++)
      if (got[i] !== pat[i]) bad++;
    tests++;
    if (got.size() != 4 || bad != 0) begin
      fails++;
      $display("FAIL basic_seq got n=%0d bad=%0d exp n=4 bad=0",
               got.size(), bad);
    end
    tests++;
    if (pc !== 10'd4 || done !== 1'b1 || vec_out !== 3'b111) begin
      fails++;
      $display("FAIL basic_end got pc%0d d%b %b exp pc4 d1 111",
               pc, done, vec_out);
    end
  endtask

  task automatic test_zero_len;
    int nv;
    got.delete();
    pulse_start(11'd0);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || pc !== 10'd0) begin
      fails++;
      $display("FAIL zero_state got d%b b%b pc%0d exp d1 b0 pc0",
               done, busy, pc);
    end
    repeat (4) @(negedge clock);
    nv = got.size();
    tests++;
    if (nv != 0) begin
      fails++; $display("FAIL zero_valid got %0d exp 0", nv);
    end
  endtask

  task automatic test_pause_step;
    bit ok;
    int bad;
    fill(8);
    got.delete();
    pulse_start(11'd8);
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_done got d%b b%b exp d0 b1", done, busy);
    end
    wait_pc(10'd3, ok);
    stop = 1'b1;
    @(negedge clock);
    tests++;
    if (!ok || vec_valid !== 1'b0 || pc !== 10'd3) begin
      fails++;
      $display("FAIL pause_hold got v%b pc%0d exp v0 pc3",
               vec_valid, pc);
    end
    @(negedge clock);
    stop = 1'b0;
    tests++;
    if (pc !== 10'd3 || busy !== 1'b1 || got.size() != 3) begin
      fails++;
      $display("FAIL pause_stop got pc%0d b%b n%0d exp pc3 b1 n3",
               pc, busy, got.size());
    end
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      tests++;
      if (vec_valid !== 1'b1 || pc !== 10'(4 + k)) begin
        fails++;
        $display("FAIL step%0d got v%b pc%0d exp v1 pc%0d",
                 k, vec_valid, pc, 4 + k);
      end
      @(negedge clock);
    end
    tests++;
    if (vec_valid !== 1'b0 || pc !== 10'd5 || got.size() != 5) begin
      fails++;
      $display("FAIL step_end got v%b pc%0d n%0d exp v0 pc5 n5",
               vec_valid, pc, got.size());
    end
    pulse_start(11'd8);
    wait_idle(20, ok);
    bad = 0;
    for (int i = 0; i < got.size() && i < 8; i++)
      if (got[i] !== mdl_mem[i]) bad++;
    tests++;
    if (!ok || got.size() != 8 || bad != 0 || pc !== 10'd8) begin
      fails++;
      $display("FAIL resume got ok%0d n%0d bad%0d pc%0d exp 1 8 0 8",
               ok, got.size(), bad, pc);
    end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    int bad;
    fill(10);
    got.delete();
    pulse_start(11'd10);
    wait_pc(10'd5, ok);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++;
    if (!ok || pc !== 10'd0 || vec_out !== 3'b000 ||
        busy !== 1'b0 || done !== 1'b0 || vec_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst got pc%0d %b b%b d%b v%b exp 0 000 0 0 0",
               pc, vec_out, busy, done, vec_valid);
    end
    tests++;
    if (got.size() != 5) begin
      fails++; $display("FAIL mid_rst_cnt got %0d exp 5", got.size());
    end
    start = 1'b1;
    stop  = 1'b1;
    step  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_prio got b%b d%b exp b0 d0", busy, done);
    end
    got.delete();
    pulse_start(11'd4);
    wait_idle(20, ok);
    bad = 0;
    for (int i = 0; i < got.size() && i < 4; i++)
      if (got[i] !== mdl_mem[i]) bad++;
    tests++;
    if (!ok || got.size() != 4 || bad != 0) begin
      fails++;
      $display("FAIL replay got ok%0d n%0d bad%0d exp 1 4 0",
               ok, got.size(), bad);
    end
  endtask

  task automatic test_load_busy;
    bit ok;
    int bad;
    got.delete();
    @(negedge clock);
    ld_if.load_we   = 1'b1;
    ld_if.load_addr = 10'd0;
    ld_if.load_data = ~mdl_mem[0];
    mdl_mem[0]      = ~mdl_mem[0];
    length          = 11'd6;
    start           = 1'b1;
    @(negedge clock);
    start           = 1'b0;
    ld_if.load_addr = 10'd2;
    ld_if.load_data = ~mdl_mem[2];
    @(negedge clock);
    ld_if.load_we   = 1'b0;
    wait_idle(20, ok);
    bad = 0;
    for (int i = 0; i < got.size() && i < 6; i++)
      if (got[i] !== mdl_mem[i]) bad++;
    tests++;
    if (!ok || got.size() != 6 || bad != 0) begin
      fails++;
      $display("FAIL load_run got ok%0d n%0d bad%0d exp 1 6 0",
               ok, got.size(), bad);
    end
    got.delete();
    pulse_start(11'd3);
    wait_idle(20, ok);
    tests++;
    if (!ok || got.size() != 3 || got[2] !== mdl_mem[2]) begin
      fails++;
      $display("FAIL load_busy got n%0d m2=%b exp n3 m2=%b",
               got.size(), (got.size() > 2) ? got[2] : 3'bxxx,
               mdl_mem[2]);
    end
  endtask

  task automatic test_clamp;
    bit ok;
    int bad;
    fill(DEPTH);
    got.delete();
    pulse_start(11'd2000);
    wait_idle(DEPTH + 20, ok);
    bad = 0;
    for (int i = 0; i < got.size() && i < DEPTH; i++)
      if (got[i] !== mdl_mem[i]) bad++;
    tests++;
    if (!ok || got.size() != DEPTH || bad != 0) begin
      fails++;
      $display("FAIL clamp got ok%0d n%0d bad%0d exp 1 %0d 0",
               ok, got.size(), bad, DEPTH);
    end
    tests++;
    if (pc !== 10'(DEPTH)) begin
      fails++; $display("FAIL clamp_pc got %0d exp %0d", pc, DEPTH);
    end
  endtask

  task automatic test_signature;
    bit ok;
    int unsigned s;
    s = 0;
`ifdef STIM_SIGNATURE_EN
    for (int k = 0; k < 4; k++) begin
      s = s * 2;
      if (s >= 65536) s = (s - 65536) ^ 32'h1021;
      s = s ^ 32'h3F;
    end
`endif
    dut_rsp = 6'h3F;
    pulse_start(11'd4);
    wait_idle(20, ok);
    tests++;
    if (!ok || signature !== 16'(s)) begin
      fails++;
      $display("FAIL signature got %h exp %h", signature, 16'(s));
    end
    dut_rsp = 6'h00;
  endtask

  initial begin
    ld_if.load_we   = 1'b0;
    ld_if.load_addr = '0;
    ld_if.load_data = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_pause_step();
    test_reset_mid_run();
    test_load_busy();
    test_clamp();
    test_signature();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stim_vec_sequencer.md
Name: stim_vec_sequencer

Overview:
- Synthesizable stimulus sequencer that replays a preloaded vector memory onto the input pins of a small control DUT (b06-class interrupt handler: __obs, cont_eql, eql), one vector per clock.
- Replaces free-running program-counter benches with a controllable engine: run, pause, single-step, bounded length and done reporting.
- Sits between the concolic harness (vector loader and run control) and the DUT; optionally compacts DUT responses into a signature.

Parameters:
VEC_W, 3, width of one stimulus vector; bit order {__obs, cont_eql, eql}
DEPTH, 1011, number of vector memory entries
ADDR_W, 10, address and pc width; must satisfy 2**ADDR_W >= DEPTH
RSP_W, 6, width of captured DUT response bus ({cc_mux, uscite, enable_count, ackout})

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
load_we  in  1  vector memory write enable; honoured only in IDLE or DONE
load_addr  in  ADDR_W  write address; writes with load_addr >= DEPTH are dropped
load_data  in  VEC_W  write data
length  in  ADDR_W+1  number of vectors to issue; sampled on the accepted start
start  in  1  begin a run from pc 0 (IDLE/DONE), or resume (PAUSE)
stop  in  1  pause request
step  in  1  issue exactly one vector while in PAUSE
dut_rsp  in  RSP_W  DUT outputs, sampled every clock
vec_out  out  VEC_W  registered stimulus to the DUT
vec_valid  out  1  high in cycles where vec_out carries a newly issued vector
pc  out  ADDR_W  index of the next vector to issue
busy  out  1  high in RUN or PAUSE
done  out  1  sticky; high in DONE
signature  out  16  response signature (see Optional Feature)

Behaviour:
- FSM states: IDLE, RUN, PAUSE, DONE. Vector memory is synchronous write; the read is registered into vec_out.
- Reset: state IDLE, pc 0, vec_out 0, vec_valid 0, busy 0, done 0, signature 0, latched length 0. Memory contents are not cleared. Reset mid-run aborts immediately, with no further vectors.
- IDLE/DONE + start:
  - latch len = min(length, DEPTH), pc <= 0.
  - If len == 0, go to DONE (done=1, no vectors issued).
  - Otherwise go to RUN.
  - Restarting from DONE clears done in the same edge.
- RUN: each cycle vec_out <= mem[pc], vec_valid <= 1, pc <= pc+1.
  - The first vector appears on vec_out 2 cycles after the start edge: 1 cycle to enter RUN, 1 read cycle.
  - When the issued index == len-1, the next state is DONE and pc = len.
  - stop in RUN: no vector issued that cycle; go to PAUSE. vec_out holds its last value and vec_valid = 0.
- PAUSE:
  - step issues one vector exactly as in RUN and stays in PAUSE, or goes to DONE if it was the last vector.
  - start resumes RUN at the current pc.
  - stop alone has no effect.
- DONE: vec_out holds the last vector, vec_valid = 0, done = 1 until start or reset.
- Priority for simultaneous inputs: reset > stop > start > step. start+stop in RUN gives PAUSE. start+stop in IDLE stays IDLE. step outside PAUSE is ignored.
- load_we in RUN/PAUSE is ignored, so memory is never modified mid-run. A load in the same cycle as start in IDLE is written; the run reads the new data.
- vec_valid is never high for more than len cycles in total per run.
- pc width: with len = DEPTH, pc ends at DEPTH and never wraps.

Optional Feature:
- Macro: STIM_SIGNATURE_EN.
- Defined: 16-bit MISR (polynomial x^16+x^12+x^5+1) folds dut_rsp into signature every cycle whose previous cycle had vec_valid=1, so the DUT response to each vector is captured once. The MISR is cleared on reset and on an accepted start from IDLE/DONE; resume from PAUSE does not clear it.
- Undefined: signature tied to 16'h0000, no MISR logic.

Decomposition:
- Package stim_seq_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - default widths: VEC_W, ADDR_W, RSP_W
  - MISR polynomial constant 16'h1021
  - vector field bit positions OBS_BIT=2, CONT_EQL_BIT=1, EQL_BIT=0
- One sub-module: stim_vec_ram (DEPTH x VEC_W, 1 write port, registered read port).
- FSM, pc and MISR stay in the top.

Test Plan:
- Load mem[0..3]=3'b001,010,100,111, length=4, pulse start → vec_out shows 001,010,100,111 on 4 consecutive cycles starting 2 cycles after start; then done=1, pc=4, vec_valid=0.
- length=0, start → DONE in 1 cycle, vec_valid never asserted.
- length=8, stop held at cycle 3 of RUN → vec_valid drops and pc holds at 3. Then step ×2 → 2 single vectors, pc=5. Then start → remaining 3 vectors, done=1.
- Assert reset during RUN at pc=5 → next cycle state IDLE, pc=0, vec_out=0, busy=0. A subsequent start replays from mem[0], showing memory was kept.
- load_we with load_addr=2 while busy → after the run, mem[2] is unchanged (verified on replay). length=2000 → clamped: exactly 1011 vectors, pc=1011.
- STIM_SIGNATURE_EN with dut_rsp=6'h3F constant for a 4-vector run → signature matches the reference MISR value computed by the bench model. Without the macro, signature=0.
